// File: rtl/disp_sel_ctrl_pkg.sv
// Shared definitions for the display page-select controller.
//
// Holds the page-select encodings used by disp_sel_ctrl and by the
// seven-segment driver that consumes sel, plus a helper that advances
// the page with wrap-around.
package disp_sel_ctrl_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_INSTR_LO = 3'd0;
    localparam logic [SEL_W-1:0] SEL_INSTR_HI = 3'd1;
    localparam logic [SEL_W-1:0] SEL_PC_LO    = 3'd2;
    localparam logic [SEL_W-1:0] SEL_PC_HI    = 3'd3;
    localparam logic [SEL_W-1:0] SEL_ALU_LO   = 3'd4;
    localparam logic [SEL_W-1:0] SEL_ALU_HI   = 3'd5;
    localparam logic [SEL_W-1:0] SEL_LAST     = SEL_ALU_HI;

    // Next page in the ring 0..SEL_LAST. The >= comparison also pulls any
    // out-of-range value straight back to the first page.
    function automatic logic [SEL_W-1:0] sel_advance(input logic [SEL_W-1:0] s);
        return (s >= SEL_LAST) ? SEL_INSTR_LO : s + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce counter and
// rising-edge detector.
//
// Ports:
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   btn_raw in  1  raw asynchronous button level
//   press   out 1  one-cycle pulse when the accepted level goes 0->1
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    // Count value reached on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                // Agreement (including the end of a short glitch) discards
                // any partial count.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                // Only an accepted 0->1 change is a press; releases are silent.
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/disp_sel_ctrl.sv
// Display page-select and freeze controller for a seven-segment debug view.
//
// Two debounced buttons drive it: btn_next steps sel through the pages
// 0..5 (wrapping), btn_freeze toggles a hold on the captured pipeline
// values. While unfrozen the captured values track the live inputs with
// one cycle of latency; paging keeps working while frozen.
//
// Ports:
//   clk         in  1   system clock
//   rst_n       in  1   asynchronous active-low reset
//   btn_next    in  1   raw button, press advances the page
//   btn_freeze  in  1   raw button, press toggles freeze
//   instruction in  32  live instruction word
//   pc_out      in  32  live program counter
//   alu_out     in  32  live ALU result
//   sel         out 3   page select, 0..5
//   instr_disp  out 32  captured instruction
//   pc_disp     out 32  captured program counter
//   alu_disp    out 32  captured ALU result
//   frozen      out 1   high while captured values are held
module disp_sel_ctrl
    import disp_sel_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_next,
    input  logic             btn_freeze,
    input  logic [31:0]      instruction,
    input  logic [31:0]      pc_out,
    input  logic [31:0]      alu_out,
    output logic [SEL_W-1:0] sel,
    output logic [31:0]      instr_disp,
    output logic [31:0]      pc_disp,
    output logic [31:0]      alu_disp,
    output logic             frozen
);

    logic next_press;
    logic freeze_press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_next_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_next),
        .press  (next_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_freeze_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_freeze),
        .press  (freeze_press)
    );

    // Page select and freeze are independent, so simultaneous presses both
    // land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel    <= SEL_INSTR_LO;
            frozen <= 1'b0;
        end else begin
            if (next_press) begin
                sel <= sel_advance(sel);
            end
            if (freeze_press) begin
                frozen <= ~frozen;
            end
        end
    end

    // Capture is gated by the registered frozen flag, so the edge on which
    // frozen rises still loads the live values: that snapshot is the one held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_disp <= '0;
            pc_disp    <= '0;
            alu_disp   <= '0;
        end else if (!frozen) begin
            instr_disp <= instruction;
            pc_disp    <= pc_out;
            alu_disp   <= alu_out;
        end
    end

endmodule

// File: tb/tb_disp_sel_ctrl.sv
// Self-checking bench for disp_sel_ctrl with DEBOUNCE_CYCLES=4.
// Table-driven press sequences, hand-written corner cases, then random
// button/data stimulus compared against a behavioural reference model.
module tb_disp_sel_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_next;
    logic        btn_freeze;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] alu_out;
    logic [2:0]  sel;
    logic [31:0] instr_disp;
    logic [31:0] pc_disp;
    logic [31:0] alu_disp;
    logic        frozen;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    disp_sel_ctrl #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (3)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_next   (btn_next),
        .btn_freeze (btn_freeze),
        .instruction(instruction),
        .pc_out     (pc_out),
        .alu_out    (alu_out),
        .sel        (sel),
        .instr_disp (instr_disp),
        .pc_disp    (pc_disp),
        .alu_disp   (alu_disp),
        .frozen     (frozen)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A button level is accepted once the last N raw samples all disagree
    // with it. The visible effect of an accepted press lags the last sample
    // by three edges (two synchronizer stages plus the pulse register).
    bit          h_n[$];
    bit          h_f[$];
    bit          lvl_n, lvl_f;
    bit          pipe_n[$];
    bit          pipe_f[$];
    int          m_sel;
    bit          m_frozen;
    logic [31:0] m_instr, m_pc, m_alu;

    function automatic bit window_all(input bit q[$], input bit v);
        if (q.size() < N) return 1'b0;
        foreach (q[i]) if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        h_n.delete(); h_f.delete();
        lvl_n = 0; lvl_f = 0;
        pipe_n = '{0, 0, 0};
        pipe_f = '{0, 0, 0};
        m_sel = 0; m_frozen = 0;
        m_instr = '0; m_pc = '0; m_alu = '0;
    endtask

    task automatic model_edge();
        bit eff_n, eff_f, rise_n, rise_f;
        if (!rst_n) begin
            model_reset();
            return;
        end
        eff_n = pipe_n.pop_front();
        eff_f = pipe_f.pop_front();
        h_n.push_back(btn_next);
        h_f.push_back(btn_freeze);
        if (h_n.size() > N) void'(h_n.pop_front());
        if (h_f.size() > N) void'(h_f.pop_front());
        rise_n = 0;
        rise_f = 0;
        if (window_all(h_n, !lvl_n)) begin lvl_n = !lvl_n; rise_n = lvl_n; end
        if (window_all(h_f, !lvl_f)) begin lvl_f = !lvl_f; rise_f = lvl_f; end
        pipe_n.push_back(rise_n);
        pipe_f.push_back(rise_f);
        if (!m_frozen) begin
            m_instr = instruction;
            m_pc    = pc_out;
            m_alu   = alu_out;
        end
        if (eff_n) m_sel = (m_sel + 1) % 6;
        if (eff_f) m_frozen = !m_frozen;
    endtask

    // One clock: model sees the inputs the edge will sample, then outputs
    // are examined 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit nxt, input bit frz);
        btn_next   = nxt;
        btn_freeze = frz;
        repeat (10) step();
        btn_next   = 0;
        btn_freeze = 0;
        repeat (10) step();
    endtask

    typedef struct {
        bit nxt;
        bit frz;
        int exp_sel;
        bit exp_frozen;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int s0;
        int hold_n, hold_f;

        // Press table: 11 next presses walk past the wrap, then a simultaneous
        // next+freeze at sel=5, unfreeze, and set up sel=3/frozen=1.
        vecs[0]  = '{1, 0, 1, 0};
        vecs[1]  = '{1, 0, 2, 0};
        vecs[2]  = '{1, 0, 3, 0};
        vecs[3]  = '{1, 0, 4, 0};
        vecs[4]  = '{1, 0, 5, 0};
        vecs[5]  = '{1, 0, 0, 0};
        vecs[6]  = '{1, 0, 1, 0};
        vecs[7]  = '{1, 0, 2, 0};
        vecs[8]  = '{1, 0, 3, 0};
        vecs[9]  = '{1, 0, 4, 0};
        vecs[10] = '{1, 0, 5, 0};
        vecs[11] = '{1, 1, 0, 1};
        vecs[12] = '{0, 1, 0, 0};
        vecs[13] = '{1, 0, 1, 0};
        vecs[14] = '{1, 0, 2, 0};
        vecs[15] = '{1, 0, 3, 0};
        vecs[16] = '{0, 1, 3, 1};

        rst_n       = 0;
        btn_next    = 0;
        btn_freeze  = 0;
        instruction = 32'hA5A5_0001;
        pc_out      = 32'h0000_1000;
        alu_out     = 32'hC3C3_0002;
        model_reset();
        #12;
        check("reset_sel", 32'(sel), 0);
        check("reset_frozen", 32'(frozen), 0);
        check("reset_instr", instr_disp, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        step();

        // Table-driven presses
        for (int i = 0; i < 17; i++) begin
            press(vecs[i].nxt, vecs[i].frz);
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_frozen", i), 32'(frozen), 32'(vecs[i].exp_frozen));
        end

        // Glitch of 3 cycles: shorter than the debounce window
        btn_next = 1;
        repeat (3) step();
        btn_next = 0;
        repeat (10) step();
        check("glitch_sel", 32'(sel), 3);
        check("glitch_cnt", 32'(u_dut.u_next_db.cnt), 0);

        // Reset mid-count with sel=3, frozen=1: effect without a clock edge
        btn_next = 1;
        repeat (4) step();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("async_rst_sel", 32'(sel), 0);
        check("async_rst_frozen", 32'(frozen), 0);
        check("async_rst_instr", instr_disp, 0);
        check("async_rst_pc", pc_disp, 0);
        check("async_rst_alu", alu_disp, 0);
        btn_next = 0;
        repeat (3) step();
        rst_n = 1;
        repeat (20) step();
        check("post_rst_no_pulse", 32'(sel), 0);

        // Capture latency and freeze hold
        instruction = 32'h0000_0001;
        step();
        check("instr_follow1", instr_disp, 32'h0000_0001);
        instruction = 32'hDEAD_BEEF;
        pc_out      = 32'h0040_0010;
        alu_out     = 32'h0BAD_F00D;
        check("instr_latency", instr_disp, 32'h0000_0001);
        step();
        check("instr_follow2", instr_disp, 32'hDEAD_BEEF);
        press(0, 1);
        check("freeze_on", 32'(frozen), 1);
        instruction = 32'h1234_5678;
        pc_out      = 32'h0000_0044;
        alu_out     = 32'h0000_0099;
        repeat (5) step();
        check("hold_instr", instr_disp, 32'hDEAD_BEEF);
        check("hold_pc", pc_disp, 32'h0040_0010);
        check("hold_alu", alu_disp, 32'h0BAD_F00D);
        press(1, 0);
        check("page_while_frozen", 32'(sel), 1);
        check("still_held", instr_disp, 32'hDEAD_BEEF);
        press(0, 1);
        check("freeze_off", 32'(frozen), 0);
        check("resume_follow", instr_disp, 32'h1234_5678);

        // Button held for 1000 cycles gives exactly one step
        s0 = int'(sel);
        btn_next = 1;
        repeat (1000) step();
        check("long_hold_sel", 32'(sel), 32'((s0 + 1) % 6));
        btn_next = 0;
        repeat (10) step();
        check("long_hold_release", 32'(sel), 32'((s0 + 1) % 6));

        // Random stimulus against the reference model
        rst_n = 0;
        model_reset();
        repeat (2) step();
        rst_n  = 1;
        hold_n = 1;
        hold_f = 1;
        for (int c = 0; c < 3000; c++) begin
            if (--hold_n == 0) begin
                btn_next = !btn_next;
                hold_n   = int'($urandom_range(1, 10));
            end
            if (--hold_f == 0) begin
                btn_freeze = !btn_freeze;
                hold_f     = int'($urandom_range(1, 14));
            end
            instruction = $urandom;
            pc_out      = $urandom;
            alu_out     = $urandom;
            step();
            check("rnd_sel", 32'(sel), 32'(m_sel));
            check("rnd_frozen", 32'(frozen), 32'(m_frozen));
            check("rnd_instr", instr_disp, m_instr);
            check("rnd_pc", pc_disp, m_pc);
            check("rnd_alu", alu_disp, m_alu);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
